mem_bus_arbiter: RTL and testbench

- Shares the single external SRAM-like memory bus between the pipeline's instruction-fetch port and its data (MEM-stage) port.
- Allows one outstanding transaction at a time. The data port has fixed priority over the fetch port.
- Sits between the datapath/controller and the memory interface. It produces the fetch and memory stall terms consumed by the hazard unit.
- Bus handshake is two-phase: an address phase (`bus_addr_ok`) followed by a data phase (`bus_data_ok`).

---
 rtl/mem_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single SRAM-like memory bus between the fetch port and the data port.
// One transaction is in flight at a time; the data port has fixed priority over fetch.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_ok,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [STRB_W-1:0] data_wstrb,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_ok,

    output logic              stall_if,
    output logic              stall_mem,

    output logic              bus_req,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [STRB_W-1:0] bus_wstrb,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,

    output logic [2:0]        dbg_state
);

    // Handshake: a requester holds req and its fields stable until its ok pulse.
    // On the bus, the address phase completes on the cycle bus_req & bus_addr_ok,
    // and the data phase completes on the first bus_data_ok seen in a DATA state.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_ADDR = 3'd1,
        I_DATA = 3'd2,
        D_ADDR = 3'd3,
        D_DATA = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t state;

    assign dbg_state = state;

    // Stall drops in the ok cycle so the pipeline advances exactly once per completion.
    assign stall_if  = inst_req & ~inst_ok;
    assign stall_mem = data_req & ~data_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bus_req    <= 1'b0;
            bus_wr     <= 1'b0;
            bus_addr   <= '0;
            bus_wstrb  <= '0;
            bus_wdata  <= '0;
            inst_ok    <= 1'b0;
            data_ok    <= 1'b0;
            inst_rdata <= '0;
            data_rdata <= '0;
        end else begin
            inst_ok <= 1'b0;
            data_ok <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_req && !data_ok) begin
                        bus_req   <= 1'b1;
                        bus_wr    <= data_wr;
                        bus_addr  <= data_addr;
                        bus_wstrb <= data_wr ? data_wstrb : '0;
                        bus_wdata <= data_wdata;
                        state     <= D_ADDR;
                    end else if (inst_req && !inst_ok) begin
                        bus_req   <= 1'b1;
                        bus_wr    <= 1'b0;
                        bus_addr  <= inst_addr;
                        bus_wstrb <= '0;
                        state     <= I_ADDR;
                    end
                end
                I_ADDR: begin
                    if (bus_addr_ok) begin
                        bus_req <= 1'b0;
                        state   <= I_DATA;
                    end
                end
                D_ADDR: begin
                    if (bus_addr_ok) begin
                        bus_req <= 1'b0;
                        state   <= D_DATA;
                    end
                end
                I_DATA: begin
                    if (bus_data_ok) begin
                        inst_rdata <= bus_rdata;
                        inst_ok    <= 1'b1;
                        state      <= DONE;
                    end
                end
                D_DATA: begin
                    if (bus_data_ok) begin
                        data_rdata <= bus_rdata;
                        data_ok    <= 1'b1;
                        state      <= DONE;
                    end
                end
                // The ok cycle: no grant here, so a requester still holding req is not reissued.
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter: a bus slave model, two requester
// drivers, and a monitor checking completions against a latency/priority reference model.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ok;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ok;
    logic        stall_if;
    logic        stall_mem;
    logic        bus_req;
    logic        bus_wr;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic [2:0]  dbg_state;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STRB_W(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ok(inst_ok),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_wstrb(data_wstrb),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ok(data_ok),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- reference model queues ----------------
    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          aw;
        int          dw;
        logic [31:0] rdata;
    } bus_t;

    typedef struct {
        bit          is_data;
        bit          rd_known;
        logic [31:0] rdata;
        int          cyc;
    } ok_t;

    bus_t bus_q[$];
    ok_t  ok_q[$];

    logic [31:0] m_inst_rd = '0;
    logic [31:0] m_data_rd = '0;
    bit          m_data_known = 1'b1;

    // ---------------- bus slave ----------------
    initial begin
        bus_t e;
        bit   known;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = '0;
        forever begin
            @(negedge clk);
            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b0;
            if (rst && bus_req) begin
                known = (bus_q.size() != 0);
                if (known) begin
                    e = bus_q.pop_front();
                end else begin
                    chk("unexpected_bus_req", 64'd1, 64'd0);
                    e = '{addr: '0, wr: 1'b0, strb: '0, wdata: '0, aw: 0, dw: 0, rdata: $urandom};
                end
                for (int w = 0; w <= e.aw; w++) begin
                    if (w > 0) @(negedge clk);
                    bus_data_ok = 1'b0;
                    if (known) begin
                        chk("bus_req_held", bus_req, 1);
                        chk("bus_addr", bus_addr, e.addr);
                        chk("bus_wr", bus_wr, e.wr);
                        chk("bus_wstrb", bus_wstrb, e.strb);
                        if (e.wr) chk("bus_wdata", bus_wdata, e.wdata);
                    end
                    // stray data_ok during the address phase must be ignored
                    if (w < e.aw && $urandom_range(0, 3) == 0) begin
                        bus_data_ok = 1'b1;
                        bus_rdata   = $urandom;
                    end
                end
                bus_addr_ok = 1'b1;
                @(negedge clk);
                bus_addr_ok = 1'b0;
                if (rst) chk("bus_req_drop", bus_req, 0);
                repeat (e.dw) @(negedge clk);
                bus_data_ok = 1'b1;
                bus_rdata   = e.rdata;
            end else if ($urandom_range(0, 3) == 0) begin
                bus_data_ok = 1'b1;
                bus_rdata   = $urandom;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        ok_t o;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                m_inst_rd    = '0;
                m_data_rd    = '0;
                m_data_known = 1'b1;
                continue;
            end
            chk("stall_if", stall_if, inst_req & ~inst_ok);
            chk("stall_mem", stall_mem, data_req & ~data_ok);
            if (inst_ok || data_ok) begin
                if (inst_ok && data_ok) chk("both_ok", 64'd1, 64'd0);
                if (ok_q.size() == 0) begin
                    chk("unexpected_ok", 64'd1, 64'd0);
                end else begin
                    o = ok_q.pop_front();
                    chk("ok_port_is_data", data_ok, o.is_data);
                    chk("ok_cycle", cyc, o.cyc);
                    if (o.is_data) begin
                        m_data_known = o.rd_known;
                        m_data_rd    = o.rdata;
                    end else begin
                        m_inst_rd = o.rdata;
                    end
                end
            end
            chk("inst_rdata", inst_rdata, m_inst_rd);
            if (m_data_known) chk("data_rdata", data_rdata, m_data_rd);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ok(input bit is_d, input int n);
        int got = 0;
        int tmo = 0;
        while (got < n && tmo < 300) begin
            @(negedge clk);
            tmo++;
            if (is_d ? data_ok : inst_ok) got++;
        end
        if (got < n) chk(is_d ? "timeout_data" : "timeout_inst", got, n);
        @(negedge clk);
        if (is_d) data_req = 1'b0;
        else inst_req = 1'b0;
    endtask

    // Model: a request seen in IDLE at cycle k completes at k+3+waits; data goes first,
    // and a follower is seen in IDLE the cycle after the leader's ok (DONE) cycle.
    task automatic scenario(input bit do_i, input bit do_d, input bit hold2,
                            input logic [31:0] iaddr, input bit dwr, input logic [31:0] daddr,
                            input logic [3:0] dstrb, input logic [31:0] dwd,
                            input int aw_i, input int dw_i, input int aw_d, input int dw_d,
                            input logic [31:0] rd_i, input logic [31:0] rd_d);
        int   base;
        int   t;
        bus_t b;
        ok_t  o;
        @(negedge clk);
        base = cyc;
        if (do_d) begin
            b = '{addr: daddr, wr: dwr, strb: (dwr ? dstrb : 4'h0), wdata: dwd,
                  aw: aw_d, dw: dw_d, rdata: rd_d};
            bus_q.push_back(b);
            t = base + 3 + aw_d + dw_d;
            o = '{is_data: 1'b1, rd_known: !dwr, rdata: rd_d, cyc: t};
            ok_q.push_back(o);
            base = t + 1;
        end
        if (do_i) begin
            for (int n = 0; n < (hold2 ? 2 : 1); n++) begin
                b = '{addr: iaddr, wr: 1'b0, strb: 4'h0, wdata: '0,
                      aw: aw_i, dw: dw_i, rdata: rd_i + 32'(n)};
                bus_q.push_back(b);
                t = base + 3 + aw_i + dw_i;
                o = '{is_data: 1'b0, rd_known: 1'b1, rdata: rd_i + 32'(n), cyc: t};
                ok_q.push_back(o);
                base = t + 1;
            end
        end
        data_req   = do_d;
        data_wr    = dwr;
        data_addr  = daddr;
        data_wstrb = dstrb;
        data_wdata = dwd;
        inst_req   = do_i;
        inst_addr  = iaddr;
        fork
            if (do_d) wait_ok(1'b1, 1);
            if (do_i) wait_ok(1'b0, hold2 ? 2 : 1);
        join
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_bus_req"}, bus_req, 0);
        chk({tag, "_bus_wr"}, bus_wr, 0);
        chk({tag, "_bus_addr"}, bus_addr, 0);
        chk({tag, "_bus_wstrb"}, bus_wstrb, 0);
        chk({tag, "_bus_wdata"}, bus_wdata, 0);
        chk({tag, "_inst_ok"}, inst_ok, 0);
        chk({tag, "_data_ok"}, data_ok, 0);
        chk({tag, "_inst_rdata"}, inst_rdata, 0);
        chk({tag, "_data_rdata"}, data_rdata, 0);
        chk({tag, "_state_idle"}, dbg_state, 0);
    endtask

    task automatic reset_mid_data();
        bus_t b;
        @(negedge clk);
        b = '{addr: 32'h8000_0040, wr: 1'b0, strb: 4'h0, wdata: '0, aw: 0, dw: 8,
              rdata: 32'h1234_5678};
        bus_q.push_back(b);
        data_req   = 1'b1;
        data_wr    = 1'b0;
        data_addr  = 32'h8000_0040;
        data_wstrb = 4'hF;
        data_wdata = '0;
        repeat (3) @(negedge clk);
        chk("pre_reset_stall_mem", stall_mem, 1);
        chk("pre_reset_bus_req_low", bus_req, 0);
        rst      = 1'b0;
        data_req = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int mode;
        rst = 1'b0;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_addr = '0; data_wstrb = '0; data_wdata = '0;
        @(negedge clk);
        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // single zero-wait fetch
        scenario(1, 0, 0, 32'hBFC0_0000, 0, '0, '0, '0, 0, 0, 0, 0, 32'h3C08_0001, '0);
        // simultaneous requests: the store goes out first
        scenario(1, 1, 0, 32'hBFC0_0004, 1, 32'h8000_0010, 4'h3, 32'h0000_BEEF,
                 0, 0, 0, 0, 32'h2408_0002, 32'h5555_AAAA);
        // wait states on a load
        scenario(0, 1, 0, '0, 0, 32'h8000_0020, 4'hF, '0, 0, 0, 4, 3, '0, 32'h0BAD_F00D);
        // fetch held through its ok cycle, reissued once afterwards
        scenario(1, 0, 1, 32'hBFC0_0008, 0, '0, '0, '0, 1, 2, 0, 0, 32'h1111_0000, '0);
        // read hold: load then fetch
        scenario(0, 1, 0, '0, 0, 32'h8000_0030, 4'hF, '0, 0, 0, 1, 1, '0, 32'hDEAD_BEEF);
        scenario(1, 0, 0, 32'hBFC0_000C, 0, '0, '0, '0, 2, 1, 0, 0, 32'h2222_3333, '0);
        // reset in the middle of a data phase
        reset_mid_data();

        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 3);
            scenario(mode != 1, mode == 1 || mode == 2, mode == 3,
                     $urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), $urandom,
                     $urandom_range(0, 4), $urandom_range(0, 4),
                     $urandom_range(0, 4), $urandom_range(0, 4),
                     $urandom, $urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        chk("bus_q_drained", bus_q.size(), 0);
        chk("ok_q_drained", ok_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
